// File: rtl/spi_slave_mlf.sv
// SPI peripheral (slave) with oversampled SCLK/CS_n/MOSI, an 8-bit RX
// deserialiser, a one-deep TX holding register feeding MISO, and a per-frame
// byte counter that saturates at MAX_BYTES_PER_CS.
module spi_slave_mlf #(
    parameter int         SPI_MODE         = 0,
    parameter int         MAX_BYTES_PER_CS = 2,
    parameter logic [7:0] IDLE_TX_BYTE     = 8'h00
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [7:0]                            i_TX_Byte,
    input  logic                                  i_TX_DV,
    output logic                                  o_TX_Ready,
    output logic                                  o_RX_DV,
    output logic [7:0]                            o_RX_Byte,
    output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_count,
    output logic                                  o_TX_Underrun,
    input  logic                                  i_SPI_clk,
    input  logic                                  i_SPI_MOSI,
    input  logic                                  i_SPI_CS_n,
    output logic                                  o_SPI_MISO,
    output logic                                  o_SPI_MISO_en
);

    localparam int               CNT_W     = $clog2(MAX_BYTES_PER_CS + 1);
    localparam logic [1:0]       MODE_BITS = 2'(SPI_MODE);
    localparam logic             CPOL      = MODE_BITS[1];
    localparam logic             CPHA      = MODE_BITS[0];
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BYTES_PER_CS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic        sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic        cs_meta_r, cs_sync_r, cs_prev_r;
    logic        mosi_meta_r, mosi_sync_r;

    logic        sclk_rise_s, sclk_fall_s, lead_s, trail_s;
    logic        sample_s, shift_s, cs_fall_s;
    logic        start_s, stop_s, load_s, accept_s;
    logic [7:0]  load_byte_s;

    logic [7:0]  hold_r;
    logic [7:0]  tx_shift_r;
    logic [7:0]  rx_shift_r;
    logic [2:0]  bit_cnt_r;
    logic        load_pend_r;
    logic        underrun_pend_r;

    // Bring SCLK, CS_n and MOSI into the i_clk domain; third flop for edge detect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_meta_r <= CPOL;
            sclk_sync_r <= CPOL;
            sclk_prev_r <= CPOL;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= i_SPI_clk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            cs_meta_r   <= i_SPI_CS_n;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            mosi_meta_r <= i_SPI_MOSI;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // Translate raw SCLK edges into sample/shift strobes for the configured mode.
    always_comb begin
        sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
        sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
        cs_fall_s   = cs_prev_r & ~cs_sync_r;
        lead_s      = 1'b0;
        trail_s     = 1'b0;
        sample_s    = 1'b0;
        shift_s     = 1'b0;
        if (CPOL) begin
            lead_s  = sclk_fall_s;
            trail_s = sclk_rise_s;
        end else begin
            lead_s  = sclk_rise_s;
            trail_s = sclk_fall_s;
        end
        if ((state_r == ST_ACTIVE) && !cs_sync_r) begin
            if (CPHA) begin
                sample_s = trail_s;
                shift_s  = lead_s;
            end else begin
                sample_s = lead_s;
                shift_s  = trail_s;
            end
        end else begin
            sample_s = 1'b0;
            shift_s  = 1'b0;
        end
    end

    // Frame sequencing: next state plus start/stop/load strobes.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        stop_s  = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    start_s = 1'b1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s = 1'b1;
                if (cs_sync_r) begin
                    stop_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_sync_r) begin
                    stop_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (shift_s && load_pend_r) begin
                    // Next byte is loaded on the shift edge after the last sample,
                    // so bit 0 of the finished byte stays on MISO through its sample.
                    load_s  = 1'b1;
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Byte handed to the TX shifter on a load: holding contents or the idle filler.
    always_comb begin
        load_byte_s = IDLE_TX_BYTE;
        accept_s    = i_TX_DV & o_TX_Ready;
        if (o_TX_Ready) begin
            load_byte_s = IDLE_TX_BYTE;
        end else begin
            load_byte_s = hold_r;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // TX holding register; a load always takes the old contents, a same-cycle strobe refills it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_r     <= 8'h00;
            o_TX_Ready <= 1'b1;
        end else if (accept_s) begin
            hold_r     <= i_TX_Byte;
            o_TX_Ready <= 1'b0;
        end else if (load_s) begin
            o_TX_Ready <= 1'b1;
        end
    end

    // TX shifter and MISO; an empty-holding load is flagged and reported when its first bit is sampled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_shift_r      <= 8'h00;
            o_SPI_MISO      <= 1'b0;
            underrun_pend_r <= 1'b0;
            o_TX_Underrun   <= 1'b0;
        end else begin
            o_TX_Underrun <= 1'b0;
            if (stop_s) begin
                o_SPI_MISO      <= 1'b0;
                underrun_pend_r <= 1'b0;
            end else if (load_s) begin
                underrun_pend_r <= o_TX_Ready;
                if ((state_r == ST_ACTIVE) || (CPHA == 1'b0)) begin
                    o_SPI_MISO <= load_byte_s[7];
                    tx_shift_r <= {load_byte_s[6:0], 1'b0};
                end else begin
                    // CPHA=1 first byte: MSB appears at the first leading edge.
                    tx_shift_r <= load_byte_s;
                end
            end else if (shift_s) begin
                o_SPI_MISO <= tx_shift_r[7];
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end else if (sample_s && underrun_pend_r && (bit_cnt_r == 3'd0)) begin
                o_TX_Underrun   <= 1'b1;
                underrun_pend_r <= 1'b0;
            end
        end
    end

    // RX deserialiser, byte strobe and per-frame byte counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_shift_r  <= 8'h00;
            bit_cnt_r   <= 3'd0;
            o_RX_Byte   <= 8'h00;
            o_RX_DV     <= 1'b0;
            o_RX_count  <= '0;
            load_pend_r <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (start_s) begin
                rx_shift_r  <= 8'h00;
                bit_cnt_r   <= 3'd0;
                o_RX_count  <= '0;
                load_pend_r <= 1'b0;
            end else if (sample_s) begin
                rx_shift_r <= {rx_shift_r[6:0], mosi_sync_r};
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    o_RX_Byte   <= {rx_shift_r[6:0], mosi_sync_r};
                    o_RX_DV     <= 1'b1;
                    load_pend_r <= 1'b1;
                    if (o_RX_count != CNT_MAX) begin
                        o_RX_count <= o_RX_count + CNT_W'(1'b1);
                    end
                end
            end else if (load_s) begin
                load_pend_r <= 1'b0;
            end
        end
    end

    // MISO output enable follows the synchronised chip select.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_SPI_MISO_en <= 1'b0;
        end else if (start_s) begin
            o_SPI_MISO_en <= 1'b1;
        end else if (stop_s) begin
            o_SPI_MISO_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Bench for spi_slave_mlf: one instance per SPI mode, a bit-banged master,
// and a scoreboard of expected RX bytes/counts checked as o_RX_DV fires.
module tb_spi_slave_mlf;

    localparam int HB = 4;

    typedef struct {
        int         mode;
        logic [7:0] data;
        logic [1:0] cnt;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_byte;
    logic [3:0] tx_dv;
    logic [3:0] tx_ready, rx_dv, underrun, miso, miso_en;
    logic [7:0] rx_byte [4];
    logic [1:0] rx_count [4];
    logic [3:0] sclk, cs_n;
    logic       mosi;

    rx_exp_t    exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         und_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] mosi_bytes [4];
    logic [7:0] miso_got [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_mlf #(
            .SPI_MODE(g), .MAX_BYTES_PER_CS(2), .IDLE_TX_BYTE(8'h00)
        ) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[g]), .o_TX_Ready(tx_ready[g]),
            .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]), .o_RX_count(rx_count[g]),
            .o_TX_Underrun(underrun[g]),
            .i_SPI_clk(sclk[g]), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n[g]),
            .o_SPI_MISO(miso[g]), .o_SPI_MISO_en(miso_en[g])
        );
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int m, input logic [7:0] d, input logic [1:0] c);
        rx_exp_t e;
        e.mode = m;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard consumer: pops one expectation per o_RX_DV pulse.
    task automatic rx_monitor();
        rx_exp_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (underrun[g]) und_cnt[g]++;
                if (rx_dv[g]) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rx_unexpected: mode %0d byte %02h count %0d, none expected",
                                 g, rx_byte[g], rx_count[g]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.mode != g || rx_byte[g] !== e.data || rx_count[g] !== e.cnt) begin
                            n_err++;
                            $display("FAIL rx_byte: got mode %0d byte %02h count %0d, want mode %0d byte %02h count %0d",
                                     g, rx_byte[g], rx_count[g], e.mode, e.data, e.cnt);
                        end
                    end
                end
            end
        end
    endtask

    // Slave-side byte load with a bounded wait for o_TX_Ready.
    task automatic load_tx(input int m, input logic [7:0] b);
        int k;
        k = 0;
        while (tx_ready[m] !== 1'b1 && k < 60) begin
            wait_clks(1);
            k++;
        end
        if (tx_ready[m] !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_ready_timeout: mode %0d ready=%b, want 1 within 60 clks", m, tx_ready[m]);
        end else begin
            tx_byte  = b;
            tx_dv[m] = 1'b1;
            wait_clks(1);
            tx_dv[m] = 1'b0;
            n_vec++;
            if (tx_ready[m] !== 1'b0) begin
                n_err++;
                $display("FAIL tx_ready_drop: mode %0d ready=%b, want 0", m, tx_ready[m]);
            end
        end
    endtask

    // Bit-banged master: drives nbits of mosi_bytes, collects MISO into miso_got.
    task automatic spi_frame(input int m, input int nbits, input bit hold_cs);
        logic cpol, cpha, v0;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        for (int i = 0; i < 4; i++) miso_got[i] = 8'h00;
        sclk[m] = cpol;
        cs_n[m] = 1'b0;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mosi_bytes[i / 8][7 - (i % 8)];
                wait_clks(HB);
                sclk[m] = ~cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi = mosi_bytes[i / 8][7 - (i % 8)];
                wait_clks(HB);
                sclk[m] = cpol;
            end
            v0 = miso[m];
            miso_got[i / 8] = {miso_got[i / 8][6:0], v0};
            wait_clks(2);
            n_vec++;
            if (miso[m] !== v0) begin
                n_err++;
                $display("FAIL miso_stable: mode %0d bit %0d miso=%b, want %b held", m, i, miso[m], v0);
            end
            wait_clks(HB - 2);
            if (!cpha) sclk[m] = cpol;
        end
        wait_clks(HB);
        n_vec++;
        if (miso_en[m] !== 1'b1) begin
            n_err++;
            $display("FAIL miso_en_active: mode %0d en=%b, want 1", m, miso_en[m]);
        end
        if (!hold_cs) begin
            cs_n[m] = 1'b1;
            wait_clks(8);
        end
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d expected bytes outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_byte = 8'h00; tx_dv = 4'h0; mosi = 1'b0;
        sclk = 4'b1100; cs_n = 4'hF;
        wait_clks(3);
        for (int g = 0; g < 4; g++) begin
            n_vec++;
            if ({tx_ready[g], rx_dv[g], underrun[g], miso[g], miso_en[g]} !== 5'b10000 ||
                rx_byte[g] !== 8'h00 || rx_count[g] !== 2'd0) begin
                n_err++;
                $display("FAIL reset: mode %0d rdy/dv/und/miso/en=%b byte %02h cnt %0d, want 10000 00 0",
                         g, {tx_ready[g], rx_dv[g], underrun[g], miso[g], miso_en[g]}, rx_byte[g], rx_count[g]);
            end
        end
        rst = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_mode0_single();
        int u0;
        u0 = und_cnt[0];
        load_tx(0, 8'hA5);
        mosi_bytes[0] = 8'hFF;
        push_exp(0, 8'hFF, 2'd1);
        spi_frame(0, 8, 1'b0);
        check_drained("single");
        n_vec++;
        if (miso_got[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL single_miso: master got %02h, want a5", miso_got[0]);
        end
        n_vec++;
        if (und_cnt[0] != u0 || rx_count[0] !== 2'd1) begin
            n_err++;
            $display("FAIL single_state: underruns %0d count %0d, want 0 and 1", und_cnt[0] - u0, rx_count[0]);
        end
    endtask

    task automatic test_back_to_back();
        int u0;
        u0 = und_cnt[0];
        load_tx(0, 8'hA5);
        mosi_bytes[0] = 8'hFF;
        mosi_bytes[1] = 8'h88;
        push_exp(0, 8'hFF, 2'd1);
        push_exp(0, 8'h88, 2'd2);
        fork
            spi_frame(0, 16, 1'b0);
            load_tx(0, 8'h3C);
        join
        check_drained("b2b");
        n_vec++;
        if (miso_got[0] !== 8'hA5 || miso_got[1] !== 8'h3C) begin
            n_err++;
            $display("FAIL b2b_miso: master got %02h %02h, want a5 3c", miso_got[0], miso_got[1]);
        end
        n_vec++;
        if (und_cnt[0] != u0) begin
            n_err++;
            $display("FAIL b2b_underrun: %0d pulses, want 0", und_cnt[0] - u0);
        end
    endtask

    task automatic test_underrun();
        int u0;
        u0 = und_cnt[0];
        mosi_bytes[0] = 8'h5A;
        push_exp(0, 8'h5A, 2'd1);
        spi_frame(0, 8, 1'b0);
        check_drained("underrun");
        n_vec++;
        if (miso_got[0] !== 8'h00) begin
            n_err++;
            $display("FAIL underrun_miso: master got %02h, want 00", miso_got[0]);
        end
        n_vec++;
        if (und_cnt[0] - u0 != 1) begin
            n_err++;
            $display("FAIL underrun_pulse: %0d pulses, want 1", und_cnt[0] - u0);
        end
    endtask

    task automatic test_modes();
        int u0;
        for (int m = 1; m < 4; m++) begin
            u0 = und_cnt[m];
            load_tx(m, 8'h3C);
            mosi_bytes[0] = 8'hC3;
            push_exp(m, 8'hC3, 2'd1);
            spi_frame(m, 8, 1'b0);
            check_drained("modes");
            n_vec++;
            if (miso_got[0] !== 8'h3C || und_cnt[m] != u0) begin
                n_err++;
                $display("FAIL mode%0d_miso: master got %02h underruns %0d, want 3c and 0",
                         m, miso_got[0], und_cnt[m] - u0);
            end
        end
    endtask

    task automatic test_cs_abort();
        mosi_bytes[0] = 8'hF0;
        spi_frame(0, 5, 1'b1);
        cs_n[0] = 1'b1;
        wait_clks(3);
        n_vec++;
        if (miso_en[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_miso_en: en=%b 3 clks after CS rise, want 0", miso_en[0]);
        end
        wait_clks(5);
        n_vec++;
        if (rx_count[0] !== 2'd0 || rx_byte[0] !== 8'h5A) begin
            n_err++;
            $display("FAIL abort_hold: count %0d byte %02h, want 0 and 5a", rx_count[0], rx_byte[0]);
        end
        load_tx(0, 8'hE7);
        mosi_bytes[0] = 8'h81;
        push_exp(0, 8'h81, 2'd1);
        spi_frame(0, 8, 1'b0);
        check_drained("abort_next");
        n_vec++;
        if (miso_got[0] !== 8'hE7) begin
            n_err++;
            $display("FAIL abort_next_miso: master got %02h, want e7", miso_got[0]);
        end
    endtask

    task automatic test_midframe_reset();
        load_tx(0, 8'h42);
        mosi_bytes[0] = 8'hAA;
        spi_frame(0, 3, 1'b1);
        load_tx(0, 8'h99);
        n_vec++;
        if (miso_en[0] !== 1'b1 || tx_ready[0] !== 1'b0 || rx_byte[0] !== 8'h81) begin
            n_err++;
            $display("FAIL prereset: en %b ready %b byte %02h, want 1 0 81", miso_en[0], tx_ready[0], rx_byte[0]);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({tx_ready[0], rx_dv[0], underrun[0], miso[0], miso_en[0]} !== 5'b10000 ||
            rx_byte[0] !== 8'h00 || rx_count[0] !== 2'd0) begin
            n_err++;
            $display("FAIL midreset: rdy/dv/und/miso/en=%b byte %02h cnt %0d, want 10000 00 0",
                     {tx_ready[0], rx_dv[0], underrun[0], miso[0], miso_en[0]}, rx_byte[0], rx_count[0]);
        end
        wait_clks(2);
        cs_n[0] = 1'b1;
        sclk[0] = 1'b0;
        rst = 1'b0;
        wait_clks(8);
        load_tx(0, 8'h24);
        mosi_bytes[0] = 8'h7E;
        push_exp(0, 8'h7E, 2'd1);
        spi_frame(0, 8, 1'b0);
        check_drained("postreset");
        n_vec++;
        if (miso_got[0] !== 8'h24) begin
            n_err++;
            $display("FAIL postreset_miso: master got %02h, want 24", miso_got[0]);
        end
    endtask

    task automatic test_count_saturation();
        int u0;
        u0 = und_cnt[0];
        mosi_bytes[0] = 8'h11;
        mosi_bytes[1] = 8'h22;
        mosi_bytes[2] = 8'h33;
        push_exp(0, 8'h11, 2'd1);
        push_exp(0, 8'h22, 2'd2);
        push_exp(0, 8'h33, 2'd2);
        spi_frame(0, 24, 1'b0);
        check_drained("saturate");
        n_vec++;
        if (und_cnt[0] - u0 != 3 || miso_got[0] !== 8'h00 || miso_got[2] !== 8'h00) begin
            n_err++;
            $display("FAIL saturate_tx: underruns %0d miso %02h/%02h, want 3 and 00/00",
                     und_cnt[0] - u0, miso_got[0], miso_got[2]);
        end
    endtask

    initial begin
        fork
            rx_monitor();
            begin
                #2000000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog expired");
            end
        join_none
        test_reset();
        test_mode0_single();
        test_back_to_back();
        test_underrun();
        test_modes();
        test_cs_abort();
        test_midframe_reset();
        test_count_saturation();
        wait_clks(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_mlf.md
Name: spi_slave_mlf

Overview:
- SPI peripheral (slave) side matching the team's SPI master with automatic chip-select.
- Oversamples SCLK, CS_n and MOSI on the local system clock.
- Deserialises MOSI into bytes and serialises a preloaded TX byte onto MISO.
- Counts bytes per CS frame, so the master/slave pair can be checked back-to-back on one bench.

Parameters:
- SPI_MODE, 0, CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]; legal values 0-3.
- MAX_BYTES_PER_CS, 2, sets the byte-count width (saturation limit of o_RX_count).
- IDLE_TX_BYTE, 8'h00, byte shifted out when no TX byte is loaded.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_TX_Byte  in  8  byte to return on MISO.
- i_TX_DV  in  1  one-cycle strobe; loads i_TX_Byte.
- o_TX_Ready  out  1  holding register empty; may accept i_TX_DV.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte valid.
- o_RX_Byte  out  8  last complete received byte.
- o_RX_count  out  $clog2(MAX_BYTES_PER_CS+1)  bytes completed in current CS frame.
- o_TX_Underrun  out  1  one-cycle pulse; a byte started with the holding register empty.
- i_SPI_clk  in  1  SCLK from master (async).
- i_SPI_MOSI  in  1  MOSI from master (async).
- i_SPI_CS_n  in  1  chip select, active low (async).
- o_SPI_MISO  out  1  MISO data.
- o_SPI_MISO_en  out  1  MISO output enable; high only while CS is active.

Behaviour:
- Reset values (async on i_rst): o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0, o_RX_count=0, o_TX_Underrun=0, o_SPI_MISO=0, o_SPI_MISO_en=0. Holding register empty, FSM in IDLE. Synchronizer flops reset to the idle levels: SCLK=CPOL, CS_n=1.
- Input sync: 2-flop synchronizer on SCLK, CS_n and MOSI, plus a third flop for edge detection. Edge/level decisions lag the pins by 2-3 i_clk cycles.
- Timing requirement: SCLK half-period ≥ 4 i_clk cycles; CS_n fall to first SCLK edge ≥ 4 i_clk cycles. Behaviour outside these limits is undefined.
- Edge definitions: leading edge = transition away from CPOL; trailing edge = return to CPOL.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- FSM states:
  - IDLE: CS_n high.
    - On synced CS_n fall: RX shift and bit counter cleared, o_RX_count cleared, o_SPI_MISO_en=1, LOAD for the first byte → ACTIVE.
  - LOAD (single cycle, not a resting state):
    - TX shift register ← holding register if full, else IDLE_TX_BYTE (and o_TX_Underrun pulses).
    - Holding register marked empty; o_TX_Ready=1 next cycle.
    - CPHA=0: MSB driven on o_SPI_MISO immediately.
    - CPHA=1: MSB driven at the first shift edge.
  - ACTIVE:
    - Each sample edge: RX shifts MSB-first, bit counter +1.
    - Each shift edge: MISO advances to the next bit.
    - On the 8th sample:
      - o_RX_Byte updated, o_RX_DV pulses on the next i_clk.
      - o_RX_count increments, saturating at MAX_BYTES_PER_CS.
      - Bit counter wraps to 0.
      - LOAD for the next byte, taking effect at the next shift edge so bit 0 of the current byte is held through its sample.
    - Synced CS_n rise → IDLE.
  - Return to IDLE (CS_n rise): o_SPI_MISO_en=0. A partial byte is discarded with no o_RX_DV. o_RX_Byte and o_RX_count hold until the next CS fall.
- TX handshake:
  - i_TX_DV is accepted only when o_TX_Ready=1; o_TX_Ready drops the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored.
  - Simultaneous i_TX_DV and LOAD in the same cycle: the LOAD takes the old holding contents, and the new byte is stored for the following byte.
- Mid-frame reset: all state returns to reset values immediately; MISO is released.

Test Plan:
- Mode 0, master half-bit 4 clks, slave preloaded 0xA5, master sends 0xFF → slave o_RX_Byte=0xFF with one o_RX_DV pulse, o_RX_count=1, master receives 0xA5.
- Two bytes under one CS (0xFF then 0x88), slave loads 0xA5 then 0x3C while o_TX_Ready=1 → RX 0xFF, 0x88; o_RX_count 1 then 2; master receives 0xA5, 0x3C; no underrun.
- No TX load, master sends 0x5A → master receives IDLE_TX_BYTE 0x00, o_TX_Underrun pulses once, slave RX=0x5A.
- Repeat the 0xC3 exchange in SPI_MODE 1, 2 and 3 → RX 0xC3 in each mode; MISO bits stable across every master sample edge.
- CS_n deasserted after 5 bits → no o_RX_DV, o_RX_count unchanged, o_SPI_MISO_en=0 within 3 clks. Next frame with 0x81 → RX 0x81, o_RX_count=1.
- Assert i_rst mid-byte → all outputs at reset values the same cycle. After release, a 0x7E transfer receives 0x7E correctly.
